// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree walker.
//   - Node-word field layout helpers (bias, packed coefficients, onehot,
//     child-present bits), LSB first.
//   - Accumulator width helper for the serial MAC.
//   - Walker FSM state encoding.
package dtree_pkg;

  // The bias always occupies the bottom of the node word.
  localparam int BIAS_LSB = 0;

  // Packed coefficients follow the bias, lowest-index unmarked feature first.
  function automatic int c_lsb(input int bias_w);
    return BIAS_LSB + bias_w;
  endfunction

  // Onehot marks the single feature whose coefficient is exactly +1.
  function automatic int onehot_lsb(input int bias_w, input int features, input int coeff_w);
    return c_lsb(bias_w) + (features - 1) * coeff_w;
  endfunction

  function automatic int left_bit(input int bias_w, input int features, input int coeff_w);
    return onehot_lsb(bias_w, features, coeff_w) + features;
  endfunction

  function automatic int right_bit(input int bias_w, input int features, input int coeff_w);
    return left_bit(bias_w, features, coeff_w) + 1;
  endfunction

  // Wide enough that bias plus FEATURES products can never overflow.
  function automatic int acc_w(input int sample_w, input int coeff_w, input int bias_w,
                               input int features);
    int prod_w;
    prod_w = sample_w + coeff_w;
    return ((prod_w > bias_w) ? prod_w : bias_w) + $clog2(features) + 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_MAC,
    ST_DECIDE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/dtree_mac.sv
// Serial signed multiply-accumulate for one tree-node split.
//   clk, reset     : clock, synchronous active-high reset
//   clear          : zero the accumulator
//   load_bias      : acc <= sign-extended bias
//   step           : acc <= acc + coeff * sample
//   bias/sample/coeff : signed operands
//   acc            : signed running sum
module dtree_mac #(
  parameter int SAMPLE_W = 8,
  parameter int COEFF_W  = 4,
  parameter int BIAS_W   = 10,
  parameter int ACC_W    = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       load_bias,
  input  logic signed [BIAS_W-1:0]   bias,
  input  logic                       step,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic signed [COEFF_W-1:0]  coeff,
  output logic signed [ACC_W-1:0]    acc
);

  localparam int PW = SAMPLE_W + COEFF_W;

  // Operands are sign-extended to the full product width before multiplying.
  logic signed [PW-1:0] prod;
  assign prod = PW'(sample) * PW'(coeff);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (load_bias) begin
      acc <= ACC_W'(bias);
    end else if (step) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/dtree_walker.sv
// Decision-tree walker for spike-sorting classification.
// Arbitrates a single-port node memory between host configuration writes
// and tree walks; walks a heap-indexed tree one node at a time, evaluating
// each signed linear split with a serial MAC, and reports the heap index of
// the absent child reached.
//   clk, reset                   : clock, synchronous active-high reset
//   in_valid/in_ready/in_x       : feature-vector handshake
//   out_valid/out_ready/out_class: result handshake (class = heap index)
//   cfg_valid/cfg_ready/cfg_addr/cfg_data : host node-word writes
//   mem_ce/mem_we/mem_a/mem_d/mem_q       : node memory port (1-cycle read)
module dtree_walker #(
  parameter int WORDS           = 8,
  parameter int FEATURES        = 3,
  parameter int COEFF_BIT_DEPTH = 4,
  parameter int BIAS_BIT_DEPTH  = 10,
  parameter int SAMPLE_W        = 8,
  parameter int DEPTH           = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FEATURES*SAMPLE_W-1:0]   in_x,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(2*WORDS+1)-1:0]   out_class,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [$clog2(WORDS)-1:0]       cfg_addr,
  input  logic [DEPTH-1:0]               cfg_data,
  output logic                           mem_ce,
  output logic                           mem_we,
  output logic [$clog2(WORDS)-1:0]       mem_a,
  output logic [DEPTH-1:0]               mem_d,
  input  logic [DEPTH-1:0]               mem_q
);

  import dtree_pkg::*;

  localparam int AW         = $clog2(WORDS);
  localparam int CLS_W      = $clog2(2*WORDS+1);
  localparam int K_W        = $clog2(FEATURES+1);
  localparam int NCOEF      = FEATURES - 1;
  localparam int ACC_W      = acc_w(SAMPLE_W, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH, FEATURES);
  localparam int C_LSB      = c_lsb(BIAS_BIT_DEPTH);
  localparam int ONEHOT_LSB = onehot_lsb(BIAS_BIT_DEPTH, FEATURES, COEFF_BIT_DEPTH);
  localparam int LEFT_BIT   = left_bit(BIAS_BIT_DEPTH, FEATURES, COEFF_BIT_DEPTH);
  localparam int RIGHT_BIT  = right_bit(BIAS_BIT_DEPTH, FEATURES, COEFF_BIT_DEPTH);

  state_t state, state_nx;

  logic [FEATURES-1:0][SAMPLE_W-1:0]     x_q;
  logic [AW-1:0]                         node;
  logic [NCOEF-1:0][COEFF_BIT_DEPTH-1:0] coeffs_q;
  logic [FEATURES-1:0]                   onehot_q;
  logic                                  left_q, right_q;
  logic [K_W-1:0]                        k;     // feature being accumulated
  logic [K_W-1:0]                        cidx;  // next packed coefficient to use
  logic [CLS_W-1:0]                      out_class_q;

  logic                              accept;
  logic                              mac_load, mac_step;
  logic signed [ACC_W-1:0]           acc;
  logic signed [SAMPLE_W-1:0]        sample;
  logic signed [COEFF_BIT_DEPTH-1:0] coeff_sel;
  logic                              marked;
  logic                              acc_neg;
  logic [CLS_W-1:0]                  child;
  logic                              child_ok;

  // Word bits above the right-present flag carry no information.
  if (DEPTH > RIGHT_BIT + 1) begin : g_msbs
    logic unused_msbs;
    assign unused_msbs = ^mem_q[DEPTH-1:RIGHT_BIT+1];
  end

  // Feature/coefficient steering for the current MAC step. A marked feature
  // uses +1; unmarked features consume packed coefficients in order. With a
  // malformed onehot the coefficient run can overrun, which contributes 0.
  always_comb begin
    sample    = '0;
    marked    = 1'b0;
    coeff_sel = '0;
    for (int j = 0; j < FEATURES; j++) begin
      if (k == K_W'(j)) begin
        sample = x_q[j];
        marked = onehot_q[j];
      end
    end
    if (marked) begin
      coeff_sel = COEFF_BIT_DEPTH'(1);
    end else begin
      for (int j = 0; j < NCOEF; j++) begin
        if (cidx == K_W'(j)) coeff_sel = coeffs_q[j];
      end
    end
  end

  // Heap child: 2n+1 on a negative sum, 2n+2 otherwise. A child past the
  // end of memory is treated as absent even if its present bit is set.
  assign acc_neg  = acc[ACC_W-1];
  assign child    = (CLS_W'(node) << 1) + (acc_neg ? CLS_W'(1) : CLS_W'(2));
  assign child_ok = (acc_neg ? left_q : right_q) && (child < CLS_W'(WORDS));

  assign accept    = (state == ST_IDLE) && !reset && !cfg_valid && in_valid;
  assign out_class = out_class_q;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cfg_ready = 1'b0;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_d     = '0;
    mac_load  = 1'b0;
    mac_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_valid) begin
          cfg_ready = 1'b1;
          mem_ce    = 1'b1;
          mem_we    = 1'b1;
          mem_a     = cfg_addr;
          mem_d     = cfg_data;
        end else begin
          in_ready = 1'b1;
          if (in_valid) state_nx = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_ce   = 1'b1;
        mem_a    = node;
        state_nx = ST_LATCH;
      end
      ST_LATCH: begin
        mac_load = 1'b1;
        state_nx = ST_MAC;
      end
      ST_MAC: begin
        mac_step = 1'b1;
        if (k == K_W'(FEATURES - 1)) state_nx = ST_DECIDE;
      end
      ST_DECIDE: state_nx = child_ok ? ST_FETCH : ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // Nothing is written or accepted while reset is held.
    if (reset) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      cfg_ready = 1'b0;
      mem_ce    = 1'b0;
      mem_we    = 1'b0;
      mem_a     = '0;
      mem_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      node        <= '0;
      coeffs_q    <= '0;
      onehot_q    <= '0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      k           <= '0;
      cidx        <= '0;
      out_class_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            x_q  <= in_x;
            node <= '0;
          end
        end
        ST_LATCH: begin
          coeffs_q <= mem_q[C_LSB +: NCOEF*COEFF_BIT_DEPTH];
          onehot_q <= mem_q[ONEHOT_LSB +: FEATURES];
          left_q   <= mem_q[LEFT_BIT];
          right_q  <= mem_q[RIGHT_BIT];
          k        <= '0;
          cidx     <= '0;
        end
        ST_MAC: begin
          k <= k + 1'b1;
          if (!marked) cidx <= cidx + 1'b1;
        end
        ST_DECIDE: begin
          if (child_ok) node <= child[AW-1:0];
          else          out_class_q <= child;
        end
        default: ;
      endcase
    end
  end

  dtree_mac #(
    .SAMPLE_W (SAMPLE_W),
    .COEFF_W  (COEFF_BIT_DEPTH),
    .BIAS_W   (BIAS_BIT_DEPTH),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .load_bias (mac_load),
    .bias      (mem_q[BIAS_LSB +: BIAS_BIT_DEPTH]),
    .step      (mac_step),
    .sample    (sample),
    .coeff     (coeff_sel),
    .acc       (acc)
  );

endmodule

// File: doc/dtree_walker.md
Name: dtree_walker

Overview:
Sequences the single-port node-coefficient memory of the spike-sorting decision tree.
- Accepts one feature vector and walks the tree from root (word 0), one node at a time.
- At each node, evaluates the signed linear split with a serial MAC, one feature per cycle.
- Emits a leaf class ID when the chosen child is absent.
- Also arbitrates the memory port between host configuration writes and classification.

Parameters:
WORDS, 8, node words in memory; heap-indexed tree, children of node n at 2n+1 (left) and 2n+2 (right)
FEATURES, 3, features per spike vector
COEFF_BIT_DEPTH, 4, signed two's-complement coefficient width
BIAS_BIT_DEPTH, 10, signed bias width
SAMPLE_W, 8, signed feature width
DEPTH, 24, memory word width; must be >= 2+FEATURES+(FEATURES-1)*COEFF_BIT_DEPTH+BIAS_BIT_DEPTH; unused MSBs are written 0 and ignored

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  feature vector valid
in_ready  out  1  walker idle, no config pending
in_x  in  FEATURES*SAMPLE_W  features, feature i at bits [i*SAMPLE_W +: SAMPLE_W]
out_valid  out  1  class result valid
out_ready  in  1  consumer accepts result
out_class  out  $clog2(2*WORDS+1)  heap index of the absent child reached
cfg_valid  in  1  host write request
cfg_ready  out  1  write accepted this cycle
cfg_addr  in  $clog2(WORDS)  node address
cfg_data  in  DEPTH  node word
mem_ce, mem_we  out  1 each  memory enable / write enable
mem_a  out  $clog2(WORDS)  memory address
mem_d  out  DEPTH  memory write data
mem_q  in  DEPTH  memory read data, valid the cycle after a read with mem_ce=1

Behaviour:
- Node word fields, LSB first (defaults shown):
  - bias [9:0]
  - c1 [13:10]: coefficient of the lowest-index feature not marked in onehot
  - c2 [17:14]: coefficient of the next such feature
  - onehot [20:18]: feature with coefficient exactly +1
  - left_present [21]
  - right_present [22]
- Onehot not exactly one-hot is a configuration error; the decision result is undefined but must still terminate.
- States: IDLE, FETCH, LATCH, MAC, DECIDE, DONE.
- IDLE:
  - cfg_valid has priority over in_valid. On cfg_valid, drive cfg_ready=1, mem_ce=1, mem_we=1, mem_a=cfg_addr, mem_d=cfg_data; one write per cycle; remain IDLE.
  - in_ready = !cfg_valid.
  - On in_valid&&in_ready: latch in_x, set node=0, go to FETCH.
- FETCH: mem_ce=1, mem_we=0, mem_a=node.
- LATCH: register mem_q; acc <= sign-extended bias; k=0.
- MAC: FEATURES cycles.
  - Feature k marked in onehot: acc += x[k].
  - Otherwise: acc += coeff*x[k], with coeffs assigned in ascending feature order.
  - ACC_W = max(SAMPLE_W+COEFF_BIT_DEPTH, BIAS_BIT_DEPTH)+$clog2(FEATURES)+1 (15 by default). Signed, no saturation, no overflow possible.
- DECIDE:
  - acc >= 0 selects right (2n+2); acc < 0 selects left (2n+1).
  - Child present bit set and index < WORDS: node <= child, go to FETCH.
  - Otherwise: out_class <= child index, go to DONE.
- DONE: out_valid=1, held until out_ready; then IDLE. out_class is stable while out_valid is high.
- Timing: 6 cycles per node visited at FEATURES=3 (3+FEATURES in general). out_valid rises 1+6·N cycles after the accept edge, where N = nodes visited.
- Termination is guaranteed: the heap index strictly increases, so N ≤ $clog2(WORDS+1).
- mem_ce=0 in all states except FETCH and IDLE-with-cfg.
- Reset, including mid-walk or mid-DONE: state IDLE; out_valid=0, out_class=0, cfg_ready=0, mem_ce=0, mem_we=0, mem_a=0, mem_d=0, acc=0; in_ready=1 the cycle after reset deasserts. The in-flight result is discarded.

Decomposition:
- Shared package dtree_pkg holds:
  - field offset/width localparams (BIAS_LSB, C_LSB, ONEHOT_LSB, LEFT_BIT, RIGHT_BIT)
  - ACC_W function
  - state enum typedef
- One sub-module, dtree_mac: serial signed multiply-accumulate with clear/load-bias/step controls.
- FSM, arbitration and addressing stay in dtree_walker.

Test Plan:
- Config then classify:
  - Stimulus: write word0=0x67CBFB (onehot f0, c1=+2, c2=-1, bias=-5, both children present) and word1=0x080000 (onehot f1, no children); x=(3,1,2).
  - Required response: node0 acc=-2 → left; node1 acc=1 → right; out_class=4; out_valid 13 cycles after accept.
- Right leaf at root:
  - Stimulus: word0 with no children, bias=+1, x=0.
  - Required response: out_class=2 after 7 cycles.
- Arbitration: cfg_valid and in_valid together in IDLE → write first, in_ready=0 that cycle; classification accepted the next cycle.
- Backpressure: out_ready low 5 cycles → out_valid and out_class held; no memory reads; in_ready=0.
- Reset mid-MAC → all outputs at reset values next cycle; a fresh vector then classifies correctly.
- Out-of-range child: WORDS=8, walk reaching node 3 selecting right (index 8) with present bit set → treated absent, out_class=8.
